// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths and PC constants
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int IMM_W = 16;
  localparam logic [WORD_W-1:0] PC_INCR = 32'd4;
  localparam logic [WORD_W-1:0] PC_RESET = 32'h0000_0000;
endpackage

// File: rtl/pc_adder32.sv
// pc_adder32: 32-bit ripple-carry adder built from full-adder cells
module pc_adder32
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  logic [WORD_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WORD_W];
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: registers PC+4 or the PC-relative branch target as the next PC
module pc_next_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_WIDTH = 16,
  parameter logic [WIDTH-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     p_in,
  input  logic [IMM_WIDTH-1:0] instruct,
  input  logic                 control,
  output logic [WIDTH-1:0]     p_out
);
  logic [WIDTH-1:0] pc4, off, tgt, nxt;
  logic pc4_cout_unused, tgt_cout_unused;
  pc_adder32 u_pc4 (.a(p_in), .b(PC_INCR), .cin(1'b0), .sum(pc4), .cout(pc4_cout_unused));
  // sign-extend the word offset and scale to bytes; the top two extension bits fall off
  assign off = {{(WIDTH-IMM_WIDTH-2){instruct[IMM_WIDTH-1]}}, instruct, 2'b00};
  pc_adder32 u_tgt (.a(pc4), .b(off), .cin(1'b0), .sum(tgt), .cout(tgt_cout_unused));
  assign nxt = control ? tgt : pc4;
  always_ff @(posedge clk) p_out <= rst ? PC_RESET : nxt;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed and random checks of the registered next-PC selection
module tb_pc_next_unit;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] p_in;
  logic [15:0] instruct;
  logic control;
  logic [31:0] p_out;
  int total = 0;
  int bad = 0;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .p_in(p_in), .instruct(instruct),
    .control(control), .p_out(p_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [15:0] i, input logic c);
    logic [31:0] pc4, off;
    pc4 = p + 32'd4;
    off = {{16{i[15]}}, i} << 2;
    return c ? pc4 + off : pc4;
  endfunction

  task automatic step(input logic r, input logic [31:0] p, input logic [15:0] i, input logic c,
                      input logic [31:0] exp, input string tag);
    rst = r; p_in = p; instruct = i; control = c;
    @(posedge clk);
    #1;
    total++;
    assert (p_out === exp) else begin
      bad++;
      $error("FAIL %s: p_out=%h expected=%h", tag, p_out, exp);
    end
  endtask

  initial begin
    step(1'b1, 32'h1234_5678, 16'hABCD, 1'b1, 32'h0000_0000, "reset_edge1");
    step(1'b1, 32'hFFFF_FFFC, 16'h7FFF, 1'b0, 32'h0000_0000, "reset_edge2");
    step(1'b0, 32'h0000_0100, 16'h1234, 1'b0, 32'h0000_0104, "pc4");
    step(1'b0, 32'h0000_0100, 16'h0004, 1'b1, 32'h0000_0114, "branch_pos");
    step(1'b0, 32'h0000_0100, 16'hFFFF, 1'b1, 32'h0000_0100, "branch_neg1");
    step(1'b0, 32'h0000_0100, 16'h8000, 1'b1, 32'hFFFE_0104, "branch_min");
    step(1'b0, 32'hFFFF_FFFC, 16'h0000, 1'b0, 32'h0000_0000, "wrap_pc4");
    step(1'b0, 32'hFFFF_FFFC, 16'h0001, 1'b1, 32'h0000_0004, "wrap_branch");
    step(1'b0, 32'h0000_0010, 16'hFFFA, 1'b1, 32'hFFFF_FFFC, "neg_wrap");
    step(1'b0, 32'h7FFF_FFFC, 16'h0000, 1'b0, 32'h8000_0000, "carry_chain");
    step(1'b0, 32'h0000_0100, 16'h0004, 1'b1, 32'h0000_0114, "pre_reset");
    step(1'b1, 32'h0000_0100, 16'h0004, 1'b1, 32'h0000_0000, "mid_reset");
    step(1'b0, 32'h0000_0200, 16'h0010, 1'b1, 32'h0000_0244, "resume");
    step(1'b0, 32'h0000_0200, 16'h0010, 1'b0, 32'h0000_0204, "resume_pc4");
    for (int k = 0; k < 60; k++) begin
      logic [31:0] p;
      logic [15:0] i;
      logic c;
      p = $urandom;
      i = 16'($urandom);
      c = 1'($urandom_range(1));
      step(1'b0, p, i, c, ref_next(p, i, c), "random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
